// File: rtl/silent_update_seq.sv
// silent_update_seq: UPDATE-interface initiator for the silent low-pass filter.
// Host writes per-transducer duty/phase/cycle targets into a shadow bank. A
// commit copies the shadow bank and the step word into the active bank, which
// drives the filter. Periodic single-cycle UPDATE pulses are spaced at least
// MIN_INTERVAL cycles apart, so every pulse lands while the filter is idle.
//
// Ports:
//   CLK, RST_N       clock, synchronous active-low reset
//   INTERVAL         requested UPDATE period in cycles (0 disables pulses)
//   WE, ADDR         shadow write strobe and transducer index
//   DUTY_IN, PHASE_IN, CYCLE_IN   shadow write data
//   STEP_IN          step word, sampled on COMMIT
//   COMMIT           request to copy the shadow bank to the active bank
//   UPDATE           single-cycle pulse to the filter
//   STEP, CYCLE, DUTY, PHASE      active bank outputs
//   COMMIT_PENDING   commit accepted but not yet applied
//
// Configuration macro SILENT_COMMIT_ALIGN_EN:
//   defined   - a commit is held pending and applied on the edge that raises
//               UPDATE (or on the next edge while disabled)
//   undefined - a commit is applied on the edge that samples COMMIT
module silent_update_seq #(
  parameter int unsigned WIDTH        = 13,
  parameter int unsigned DEPTH        = 249,
  parameter int unsigned MIN_INTERVAL = DEPTH + 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [15:0]              INTERVAL,
  input  logic                     WE,
  input  logic [$clog2(DEPTH)-1:0] ADDR,
  input  logic [WIDTH-1:0]         DUTY_IN,
  input  logic [WIDTH-1:0]         PHASE_IN,
  input  logic [WIDTH-1:0]         CYCLE_IN,
  input  logic [WIDTH-1:0]         STEP_IN,
  input  logic                     COMMIT,
  output logic                     UPDATE,
  output logic [WIDTH-1:0]         STEP,
  output logic [WIDTH-1:0]         CYCLE [0:DEPTH-1],
  output logic [WIDTH-1:0]         DUTY  [0:DEPTH-1],
  output logic [WIDTH-1:0]         PHASE [0:DEPTH-1],
  output logic                     COMMIT_PENDING
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] MIN_P = CW'(MIN_INTERVAL);

  typedef enum logic {
    ST_DISABLED = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   per_q, per_d;
  logic [CW-1:0]   p_eff;
  logic            upd_d;
  logic            apply_c;
  logic            wr_en;
  logic [WIDTH-1:0] step_src;

  logic [WIDTH-1:0] sh_duty  [0:DEPTH-1];
  logic [WIDTH-1:0] sh_phase [0:DEPTH-1];
  logic [WIDTH-1:0] sh_cycle [0:DEPTH-1];

  // Writes beyond the last transducer are dropped.
  assign wr_en = WE && ({1'b0, ADDR} < (AW+1)'(DEPTH));

  // Period FSM: next state, counter and UPDATE pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    upd_d   = 1'b0;
    p_eff   = (INTERVAL > MIN_P) ? INTERVAL : MIN_P;
    case (state_q)
      ST_DISABLED: begin
        cnt_d = '0;
        if (INTERVAL != '0) begin
          state_d = ST_RUN;
          per_d   = p_eff;
        end
      end
      ST_RUN: begin
        if (cnt_q == per_q - CW'(1)) begin
          // Wrap: the period is re-evaluated here. A suppressed pulse in
          // the slot just ending means INTERVAL was 0 there, so stop.
          cnt_d = '0;
          per_d = p_eff;
          if (!UPDATE) state_d = ST_DISABLED;
        end else begin
          cnt_d = cnt_q + CW'(1);
          upd_d = (cnt_d == per_q - CW'(1)) && (INTERVAL != '0);
        end
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  // State, counter and pulse registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_DISABLED;
      cnt_q   <= '0;
      per_q   <= '0;
      UPDATE  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      UPDATE  <= upd_d;
    end
  end

`ifdef SILENT_COMMIT_ALIGN_EN
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] step_sh_q;

  // Hold the commit until the UPDATE edge; repeated commits fold into one.
  always_comb begin
    apply_c  = pend_q && ((state_q == ST_DISABLED) || upd_d);
    pend_d   = apply_c ? 1'b0 : (pend_q | COMMIT);
    step_src = COMMIT ? STEP_IN : step_sh_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend_q    <= 1'b0;
      step_sh_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (COMMIT) step_sh_q <= STEP_IN;
    end
  end

  assign COMMIT_PENDING = pend_q;
`else
  always_comb begin
    apply_c  = COMMIT;
    step_src = STEP_IN;
  end

  assign COMMIT_PENDING = 1'b0;
`endif

  // Shadow and active banks; a same-cycle write is forwarded into the copy.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      STEP <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        sh_duty[i]  <= '0;
        sh_phase[i] <= '0;
        sh_cycle[i] <= '0;
        DUTY[i]     <= '0;
        PHASE[i]    <= '0;
        CYCLE[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wr_en && (ADDR == AW'(i))) begin
          sh_duty[i]  <= DUTY_IN;
          sh_phase[i] <= PHASE_IN;
          sh_cycle[i] <= CYCLE_IN;
        end
        if (apply_c) begin
          if (wr_en && (ADDR == AW'(i))) begin
            DUTY[i]  <= DUTY_IN;
            PHASE[i] <= PHASE_IN;
            CYCLE[i] <= CYCLE_IN;
          end else begin
            DUTY[i]  <= sh_duty[i];
            PHASE[i] <= sh_phase[i];
            CYCLE[i] <= sh_cycle[i];
          end
        end
      end
      if (apply_c) STEP <= step_src;
    end
  end

endmodule

// File: tb/tb_silent_update_seq.sv
// Testbench for silent_update_seq: directed vectors, multi-cycle sequences and
// randomized traffic checked against a cycle-time reference model.
module tb_silent_update_seq;

  localparam int WIDTH = 13;
  localparam int DEPTH = 249;
  localparam int MINI  = DEPTH + 8;

  logic        clk = 1'b0;
  logic        rst_n, we, commit;
  logic [15:0] interval;
  logic [7:0]  addr;
  logic [12:0] duty_in, phase_in, cycle_in, step_in;
  logic        update, commit_pending;
  logic [12:0] step;
  logic [12:0] cyc_o   [0:DEPTH-1];
  logic [12:0] duty_o  [0:DEPTH-1];
  logic [12:0] phase_o [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  silent_update_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MIN_INTERVAL(MINI)) dut (
    .CLK(clk), .RST_N(rst_n), .INTERVAL(interval), .WE(we), .ADDR(addr),
    .DUTY_IN(duty_in), .PHASE_IN(phase_in), .CYCLE_IN(cycle_in),
    .STEP_IN(step_in), .COMMIT(commit), .UPDATE(update), .STEP(step),
    .CYCLE(cyc_o), .DUTY(duty_o), .PHASE(phase_o),
    .COMMIT_PENDING(commit_pending)
  );

  // Reference model: banks as arrays, pulse timing as absolute edge numbers.
  logic [12:0] m_sd [DEPTH];
  logic [12:0] m_sp [DEPTH];
  logic [12:0] m_sc [DEPTH];
  logic [12:0] m_ad [DEPTH];
  logic [12:0] m_ap [DEPTH];
  logic [12:0] m_ac [DEPTH];
  logic [12:0] m_step, m_stepsh;
  int n = 0;
  int m_pstart, m_plen;
  bit m_run, m_stop, m_upd, m_pend;
  bit mchk = 1'b0;

  function automatic int eff(input int iv);
    return (iv > MINI) ? iv : MINI;
  endfunction

  task automatic model(input bit r, input bit w, input bit c, input int iv,
                       input int a, input logic [12:0] d, input logic [12:0] p,
                       input logic [12:0] cy, input logic [12:0] s);
    bit was_run, nupd, apply;
    n++;
    if (!r) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_sd[i] = '0; m_sp[i] = '0; m_sc[i] = '0;
        m_ad[i] = '0; m_ap[i] = '0; m_ac[i] = '0;
      end
      m_run = 0; m_stop = 0; m_upd = 0; m_pend = 0;
      m_step = '0; m_stepsh = '0;
      mchk = 1'b1;
      return;
    end
    was_run = m_run;
    nupd = 0;
    apply = 0;
    if (!m_run) begin
      if (iv != 0) begin
        m_run = 1; m_stop = 0; m_pstart = n; m_plen = eff(iv);
      end
    end else if (n == m_pstart + m_plen) begin
      if (m_stop) m_run = 0;
      else begin
        m_pstart = n; m_plen = eff(iv);
      end
    end else if (n == m_pstart + m_plen - 1) begin
      m_stop = (iv == 0);
      nupd = !m_stop;
    end
    if (w && a < DEPTH) begin
      m_sd[a] = d; m_sp[a] = p; m_sc[a] = cy;
    end
`ifdef SILENT_COMMIT_ALIGN_EN
    if (c) m_stepsh = s;
    apply = m_pend && (!was_run || nupd);
    m_pend = apply ? 1'b0 : (m_pend || c);
    if (apply) m_step = m_stepsh;
`else
    apply = c;
    if (apply) m_step = s;
`endif
    if (apply) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_ad[i] = m_sd[i]; m_ap[i] = m_sp[i]; m_ac[i] = m_sc[i];
      end
    end
    m_upd = nupd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic chk_bank();
    int bad;
    bad = -1;
    for (int i = 0; i < DEPTH; i++)
      if (bad < 0 && (duty_o[i] !== m_ad[i] || phase_o[i] !== m_ap[i] || cyc_o[i] !== m_ac[i]))
        bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL bank[%0d] edge %0d: got d/p/c %0h/%0h/%0h want %0h/%0h/%0h", bad, n,
               duty_o[bad], phase_o[bad], cyc_o[bad], m_ad[bad], m_ap[bad], m_ac[bad]);
    end
  endtask

  // One clock: capture inputs, advance model at the edge, compare 1ns later.
  task automatic tick();
    bit r, w, c;
    int iv, a;
    logic [12:0] d, p, cy, s;
    r = rst_n; w = we; c = commit; iv = int'(interval); a = int'(addr);
    d = duty_in; p = phase_in; cy = cycle_in; s = step_in;
    @(posedge clk);
    model(r, w, c, iv, a, d, p, cy, s);
    #1;
    if (mchk) begin
      chk("model_update", 32'(update), 32'(m_upd));
      chk("model_pending", 32'(commit_pending), 32'(m_pend));
      chk("model_step", 32'(step), 32'(m_step));
      chk_bank();
    end
  endtask

  // Edges until UPDATE is seen; -1 when the bound expires.
  task automatic wait_pulse(input int bound, output int edges);
    edges = -1;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (update === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [12:0] d, p, c, s;
    bit          cm;
    int          idx;
    logic [12:0] ed, ep, ec, es;
  } vec_t;

  initial begin
    vec_t tbl [6];
    logic [15:0] ivs [5];
    int e;

    tbl[0] = '{1'b1, 8'd5,   13'h100,  13'h080,  13'h1000, 13'h000,  1'b0, 5,   13'h000,  13'h000,  13'h0000, 13'h000};
    tbl[1] = '{1'b0, 8'd0,   13'h000,  13'h000,  13'h0000, 13'h010,  1'b1, 5,   13'h100,  13'h080,  13'h1000, 13'h010};
    tbl[2] = '{1'b1, 8'd0,   13'h1FF,  13'h003,  13'h0007, 13'h020,  1'b1, 0,   13'h1FF,  13'h003,  13'h0007, 13'h020};
    tbl[3] = '{1'b1, 8'd249, 13'hAAA,  13'hBBB,  13'h0CCC, 13'h030,  1'b1, 0,   13'h1FF,  13'h003,  13'h0007, 13'h030};
    tbl[4] = '{1'b1, 8'd248, 13'h1ABC, 13'h1FFF, 13'h0001, 13'h1FFF, 1'b1, 248, 13'h1ABC, 13'h1FFF, 13'h0001, 13'h1FFF};
    tbl[5] = '{1'b1, 8'd5,   13'h0FF,  13'h0FF,  13'h00FF, 13'h000,  1'b0, 5,   13'h100,  13'h080,  13'h1000, 13'h1FFF};
    ivs[0] = 16'd0; ivs[1] = 16'd10; ivs[2] = 16'd260; ivs[3] = 16'd300; ivs[4] = 16'd520;

    // Reset with every input active: nothing may escape.
    rst_n = 1'b0; we = 1'b1; commit = 1'b1; interval = 16'd500; addr = 8'd3;
    duty_in = 13'h123; phase_in = 13'h45; cycle_in = 13'h67; step_in = 13'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_update", 32'(update), 32'd0);
    end
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_pending", 32'(commit_pending), 32'd0);
    chk("rst_duty3", 32'(duty_o[3]), 32'd0);
    rst_n = 1'b1; we = 1'b0; commit = 1'b0;
    wait_pulse(2000, e);
    chk("first_pulse_after_reset", 32'(e), 32'd500);

    // Reset mid-period restarts a fresh count.
    repeat (50) tick();
    rst_n = 1'b0;
    tick();
    chk("midreset_update", 32'(update), 32'd0);
    rst_n = 1'b1;
    wait_pulse(2000, e);
    chk("pulse_after_midreset", 32'(e), 32'd500);
    interval = 16'd0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Write/commit vectors while disabled (both commit modes settle in 2 edges).
    for (int i = 0; i < 6; i++) begin
      we = tbl[i].we; addr = tbl[i].addr; duty_in = tbl[i].d; phase_in = tbl[i].p;
      cycle_in = tbl[i].c; step_in = tbl[i].s; commit = tbl[i].cm;
      tick();
      we = 1'b0; commit = 1'b0;
      tick();
      tick();
      chk($sformatf("vec%0d_duty", i), 32'(duty_o[tbl[i].idx]), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_phase", i), 32'(phase_o[tbl[i].idx]), 32'(tbl[i].ep));
      chk($sformatf("vec%0d_cycle", i), 32'(cyc_o[tbl[i].idx]), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_step", i), 32'(step), 32'(tbl[i].es));
    end

    // Period clamping and disable.
    interval = 16'd300;
    wait_pulse(1000, e); chk("p300_first", 32'(e), 32'd300);
    wait_pulse(1000, e); chk("p300_gap", 32'(e), 32'd300);
    interval = 16'd10;
    wait_pulse(1000, e); chk("p10_gap1", 32'(e), 32'd257);
    wait_pulse(1000, e); chk("p10_gap2", 32'(e), 32'd257);
    interval = 16'd0;
    wait_pulse(600, e); chk("disabled_no_pulse", 32'(e), 32'hFFFF_FFFF);

    // INTERVAL change mid-period applies from the next wrap.
    interval = 16'd400;
    wait_pulse(1000, e); chk("p400_first", 32'(e), 32'd400);
    repeat (101) tick();
    interval = 16'd600;
    wait_pulse(1000, e); chk("retime_current_gap", 32'(e + 101), 32'd400);
    wait_pulse(1000, e); chk("retime_next_gap", 32'(e), 32'd600);
    interval = 16'd0;
    wait_pulse(1000, e); chk("retime_disable", 32'(e), 32'hFFFF_FFFF);

    // Commit timing against the UPDATE edge, P=300.
    interval = 16'd300;
    wait_pulse(1000, e); chk("p300_restart", 32'(e), 32'd300);
    we = 1'b1; addr = 8'd2; duty_in = 13'h11; phase_in = 13'h22; cycle_in = 13'h33;
    tick();                               // counter 0
    we = 1'b0;
    repeat (10) tick();                   // counter 10
    commit = 1'b1; step_in = 13'h77;
    tick();                               // counter 11
    commit = 1'b0;
`ifdef SILENT_COMMIT_ALIGN_EN
    chk("align_pending_c11", 32'(commit_pending), 32'd1);
    chk("align_duty2_held", 32'(duty_o[2]), 32'd0);
`else
    chk("imm_pending_c11", 32'(commit_pending), 32'd0);
    chk("imm_duty2_c11", 32'(duty_o[2]), 32'h11);
`endif
    repeat (88) tick();                   // counter 99
    we = 1'b1; duty_in = 13'h55;
    tick();                               // counter 100
    we = 1'b0; commit = 1'b1; step_in = 13'h78;
    tick();                               // counter 101
    commit = 1'b0;
`ifdef SILENT_COMMIT_ALIGN_EN
    chk("align_pending_c101", 32'(commit_pending), 32'd1);
    chk("align_step_held", 32'(step), 32'h1FFF);
`else
    chk("imm_duty2_c101", 32'(duty_o[2]), 32'h55);
    chk("imm_step_c101", 32'(step), 32'h78);
`endif
    repeat (197) tick();                  // counter 298
    chk("pre_update_quiet", 32'(update), 32'd0);
`ifdef SILENT_COMMIT_ALIGN_EN
    chk("align_duty2_c298", 32'(duty_o[2]), 32'd0);
`endif
    tick();                               // counter 299
    chk("commit_update", 32'(update), 32'd1);
    chk("commit_duty2", 32'(duty_o[2]), 32'h55);
    chk("commit_phase2", 32'(phase_o[2]), 32'h22);
    chk("commit_step", 32'(step), 32'h78);
    chk("commit_pending_clear", 32'(commit_pending), 32'd0);

    // Randomized traffic against the model.
    interval = 16'd260;
    for (int i = 0; i < 4000; i++) begin
      rst_n    = ($urandom % 2500) != 0;
      we       = ($urandom % 3) == 0;
      addr     = 8'($urandom);
      duty_in  = 13'($urandom);
      phase_in = 13'($urandom);
      cycle_in = 13'($urandom);
      step_in  = 13'($urandom);
      commit   = ($urandom % 30) == 0;
      if (($urandom % 600) == 0) interval = ivs[$urandom % 5];
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/silent_update_seq.md
# silent_update_seq

Update sequencer for the silent low-pass filter stage. It is the initiator side of the filter's UPDATE interface: it holds host-written target duty, phase and cycle values per transducer in a shadow bank and commits them to an active bank. It drives the filter's STEP, CYCLE, DUTY and PHASE inputs from that active bank and issues periodic single-cycle UPDATE pulses. The pulses are spaced so that every pulse lands while the filter is idle.

## Interface

**Parameters**
- WIDTH, 13: width of step, cycle, duty and phase words.
- DEPTH, 249: number of transducers.
- MIN_INTERVAL, DEPTH+8: minimum UPDATE spacing in cycles. It covers the filter's DEPTH-cycle sweep plus pipeline latency.

**Ports** (clock and reset first)
- CLK, input, 1: system clock. All logic is on the posedge.
- RST_N, input, 1: reset, synchronous, active-low.
- INTERVAL, input, 16: requested UPDATE period in cycles. 0 disables UPDATE generation.
- WE, input, 1: shadow write strobe.
- ADDR, input, $clog2(DEPTH): transducer index for the write.
- DUTY_IN, input, WIDTH: target duty for the write.
- PHASE_IN, input, WIDTH: target phase for the write.
- CYCLE_IN, input, WIDTH: cycle for the write.
- STEP_IN, input, WIDTH: shadow step value, sampled on COMMIT.
- COMMIT, input, 1: single-cycle request to copy the shadow bank to the active bank.
- UPDATE, output, 1: single-cycle pulse to the filter.
- STEP, output, WIDTH: active step value.
- CYCLE, output, WIDTH × [0:DEPTH-1]: active cycles.
- DUTY, output, WIDTH × [0:DEPTH-1]: active duty targets.
- PHASE, output, WIDTH × [0:DEPTH-1]: active phase targets.
- COMMIT_PENDING, output, 1: commit accepted but not yet applied.

## Operation

**Reset.** While RST_N=0 at a posedge, all of the following are cleared to 0: both banks, STEP, UPDATE, COMMIT_PENDING, the period counter and the FSM.

**Shadow writes.**
- WE=1 with ADDR<DEPTH writes DUTY_IN, PHASE_IN and CYCLE_IN into shadow[ADDR].
- ADDR≥DEPTH is ignored.
- The active bank is never written directly.

**Commit.**
- The commit copies all DEPTH shadow entries plus STEP_IN into the active bank and STEP in a single cycle.
- If WE and COMMIT occur in the same cycle, the write is applied to the shadow first. The committed data therefore includes it.

**Period.**
- The effective period is P = max(INTERVAL, MIN_INTERVAL), evaluated when the counter wraps.
- The counter runs 0..P-1.

**FSM.** Two states, DISABLED and RUN.
- DISABLED: counter held at 0, UPDATE=0. Transition to RUN when INTERVAL≠0.
- RUN: counter increments every cycle. UPDATE=1 in the cycle where counter==P-1, then the counter returns to 0.
- INTERVAL becoming 0 in RUN: transition to DISABLED at the next wrap. No pulse is issued for that wrap.

**Boundary conditions.**
- A change of INTERVAL mid-period takes effect only at the next wrap. Spacing between pulses is never below MIN_INTERVAL.
- A COMMIT while COMMIT_PENDING=1 is absorbed into the pending commit; the latest shadow contents win.
- RST_N low mid-period clears everything. The first pulse after release comes at cycle P-1 of a fresh count.

## Timing

- Write: shadow is visible 1 cycle after WE.
- UPDATE: first pulse P cycles after entering RUN. Subsequent pulses are exactly P cycles apart.
- The active bank and STEP are stable in the cycle UPDATE=1, and in every cycle except the commit-application edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration

Macro SILENT_COMMIT_ALIGN_EN.

**Defined (aligned commit).**
- COMMIT sets COMMIT_PENDING on the next edge.
- The copy is applied on the same edge that raises UPDATE (the edge where counter reaches P-1). The filter therefore sees the new set together with its UPDATE.
- COMMIT_PENDING clears on that edge.
- In DISABLED, a pending commit is applied on the next edge.

**Undefined (immediate commit).**
- The copy is applied on the edge after COMMIT.
- COMMIT_PENDING is tied to 0.

## Test plan

- **Reset clears state.** Hold RST_N=0 for 3 cycles with WE=1, COMMIT=1, INTERVAL=500 → all outputs are 0 and no UPDATE occurs during reset. The first UPDATE comes 500 cycles after release.
- **Period clamping.** INTERVAL=300 with DEPTH=249 → pulses are 300 cycles apart. INTERVAL=10 → pulses are 257 cycles apart. INTERVAL=0 → no pulse after the current period completes.
- **Write then commit.** Write ADDR=5 with duty=0x100, phase=0x80, cycle=0x1000, then COMMIT with STEP_IN=0x10 → DUTY[5]=0x100, PHASE[5]=0x80, CYCLE[5]=0x1000, STEP=0x10. Apply time depends on the macro (next edge, or the UPDATE edge). The other entries are unchanged.
- **Same-cycle write and commit.** WE to ADDR=0 with duty=0x1FF in the same cycle as COMMIT → the committed DUTY[0]=0x1FF.
- **Aligned commit (macro on).** COMMIT at counter=10 with P=300 → COMMIT_PENDING=1 from cycle 11 until the UPDATE edge. Outputs change only on that edge. A second COMMIT at counter=100, after writing ADDR=2 with duty=0x55, yields DUTY[2]=0x55 at that same UPDATE.
- **Out-of-range writes and mid-period retiming.** WE with ADDR=249 → no bank changes. INTERVAL changed from 400 to 600 at counter=100 → the current gap stays 400 and the next gap is 600.
